// File: rtl/snax_simbacore_ctrl_if.sv
// Bundles the CSR launch port, the SimbaCore config port and the snooped
// acc2stream handshakes. The controller uses the slave modport.
interface snax_simbacore_ctrl_if #(
  parameter int unsigned RegRWCount   = 6,
  parameter int unsigned RegROCount   = 2,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned NumOutPorts  = 4
);

  logic [RegDataWidth-1:0] csr_reg_set_i    [RegRWCount];
  logic                    csr_reg_set_valid_i;
  logic                    csr_reg_set_ready_o;
  logic [RegDataWidth-1:0] csr_reg_ro_set_o [RegROCount];

  logic                    cfg_valid_o;
  logic                    cfg_ready_i;
  logic [RegDataWidth-1:0] cfg_mode_o;
  logic [RegDataWidth-1:0] cfg_seq_len_o;
  logic [RegDataWidth-1:0] cfg_d_model_o;
  logic [RegDataWidth-1:0] cfg_dt_rank_o;
  logic [RegDataWidth-1:0] cfg_d_inner_o;

  logic [NumOutPorts-1:0]  out_valid_i;
  logic [NumOutPorts-1:0]  out_ready_i;

  // Environment side: CSR manager, SimbaCore and the stream fabric.
  modport master (
    output csr_reg_set_i,
    output csr_reg_set_valid_i,
    input  csr_reg_set_ready_o,
    input  csr_reg_ro_set_o,
    input  cfg_valid_o,
    output cfg_ready_i,
    input  cfg_mode_o,
    input  cfg_seq_len_o,
    input  cfg_d_model_o,
    input  cfg_dt_rank_o,
    input  cfg_d_inner_o,
    output out_valid_i,
    output out_ready_i
  );

  // Controller side.
  modport slave (
    input  csr_reg_set_i,
    input  csr_reg_set_valid_i,
    output csr_reg_set_ready_o,
    output csr_reg_ro_set_o,
    output cfg_valid_o,
    input  cfg_ready_i,
    output cfg_mode_o,
    output cfg_seq_len_o,
    output cfg_d_model_o,
    output cfg_dt_rank_o,
    output cfg_d_inner_o,
    input  out_valid_i,
    input  out_ready_i
  );

endinterface

// File: rtl/snax_simbacore_ctrl.sv
// Run controller between the SNAX CSR manager and the SimbaCore config port.
// Define SNAX_SIMBACORE_CTRL_PERF_EN to expose a busy-cycle counter in RO CSR 1.
module snax_simbacore_ctrl #(
  parameter int unsigned RegRWCount   = 6,
  parameter int unsigned RegROCount   = 2,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned NumOutPorts  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  snax_simbacore_ctrl_if.slave bus
);

  localparam int unsigned ExpIdx   = 5;
  localparam int unsigned IncWidth = $clog2(NumOutPorts + 1);
  localparam int unsigned SumWidth = RegDataWidth + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    RUN    = 2'd2
  } state_e;

  state_e                  state_q;
  logic [RegDataWidth-1:0] cfg_q [RegRWCount];
  logic [RegDataWidth-1:0] beat_cnt_q;
  logic                    done_q;
  logic                    cfg_valid_q;
  logic                    csr_ready_q;

  logic [NumOutPorts-1:0]  fire;
  logic [IncWidth-1:0]     inc;
  logic [SumWidth-1:0]     beat_sum;
  logic [SumWidth-1:0]     expected_ext;
  logic                    launch;
  logic                    busy;
  logic [RegDataWidth-1:0] status_word;
  logic [RegDataWidth-1:0] perf_word;

  genvar gi;

  for (gi = 0; gi < NumOutPorts; gi++) begin : g_fire
    assign fire[gi] = bus.out_valid_i[gi] & bus.out_ready_i[gi];
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < NumOutPorts; i++) begin
      inc = inc + IncWidth'(fire[i]);
    end
  end

  // One extra bit so a near-full counter plus a burst of beats cannot wrap.
  assign beat_sum     = {1'b0, beat_cnt_q} + SumWidth'(inc);
  assign expected_ext = {1'b0, cfg_q[ExpIdx]};

  // Ready is a register that mirrors state_q == IDLE.
  assign launch = csr_ready_q & bus.csr_reg_set_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      done_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
      csr_ready_q <= 1'b1;
      for (int i = 0; i < RegRWCount; i++) begin
        cfg_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            for (int i = 0; i < RegRWCount; i++) begin
              cfg_q[i] <= bus.csr_reg_set_i[i];
            end
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
            cfg_valid_q <= 1'b1;
            csr_ready_q <= 1'b0;
            state_q     <= CONFIG;
          end
        end
        CONFIG: begin
          if (bus.cfg_ready_i) begin
            cfg_valid_q <= 1'b0;
            if (cfg_q[ExpIdx] == '0) begin
              done_q      <= 1'b1;
              csr_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (beat_sum >= expected_ext) begin
            beat_cnt_q  <= cfg_q[ExpIdx];
            done_q      <= 1'b1;
            csr_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            beat_cnt_q <= beat_sum[RegDataWidth-1:0];
          end
        end
        default: begin
          cfg_valid_q <= 1'b0;
          csr_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef SNAX_SIMBACORE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q;

  // Counts CONFIG and RUN cycles; the last run's value stays readable in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (launch) begin
        cycle_cnt_q <= '0;
      end
    end else if (cycle_cnt_q != 32'hFFFF_FFFF) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign perf_word = RegDataWidth'(cycle_cnt_q);
`else
  assign perf_word = '0;
`endif

  assign busy        = (state_q != IDLE);
  assign status_word = {{(RegDataWidth-2){1'b0}}, done_q, busy};

  for (gi = 0; gi < RegROCount; gi++) begin : g_ro
    if (gi == 0) begin : g_status
      assign bus.csr_reg_ro_set_o[gi] = status_word;
    end else if (gi == 1) begin : g_perf
      assign bus.csr_reg_ro_set_o[gi] = perf_word;
    end else begin : g_zero
      assign bus.csr_reg_ro_set_o[gi] = '0;
    end
  end

  assign bus.csr_reg_set_ready_o = csr_ready_q;
  assign bus.cfg_valid_o         = cfg_valid_q;
  assign bus.cfg_mode_o          = cfg_q[0];
  assign bus.cfg_seq_len_o       = cfg_q[1];
  assign bus.cfg_d_model_o       = cfg_q[2];
  assign bus.cfg_dt_rank_o       = cfg_q[3];
  assign bus.cfg_d_inner_o       = cfg_q[4];

endmodule
